// File: rtl/core_result_collector_pkg.sv
// Shared types and constants for core_result_collector: FSM states, per-core
// slice widths, default bit positions and the minimum total width helper.
package collector_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SUM  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int RES_STROBE_BIT_DEF = 3;
    localparam int COMPLETE_BIT_DEF   = 0;
    localparam int STROBE_W           = 4;
    localparam int COMPLETE_W         = 8;

    // Narrowest total that can hold num_cores full-scale results.
    function automatic int min_sum_w(input int data_w, input int num_cores);
        return data_w + $clog2(num_cores);
    endfunction

endpackage

// File: rtl/core_result_collector_if.sv
// Bundle of the jimmy-core result buses and the collector's outputs toward the
// output mux/display path.
interface core_result_collector_if
    import collector_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int DATA_W    = 8,
    parameter int SUM_W     = 10,
    parameter int CYC_W     = 32
);

    logic [STROBE_W*NUM_CORES-1:0]   out_strobe;
    logic [DATA_W*NUM_CORES-1:0]     result_bus;
    logic [COMPLETE_W*NUM_CORES-1:0] complete_bus;
    logic [DATA_W*NUM_CORES-1:0]     core_result;
    logic [SUM_W-1:0]                total;
    logic [CYC_W-1:0]                cycle_count;
    logic                            done;
    logic                            timeout;

    modport master (
        output out_strobe, result_bus, complete_bus,
        input  core_result, total, cycle_count, done, timeout
    );

    modport slave (
        input  out_strobe, result_bus, complete_bus,
        output core_result, total, cycle_count, done, timeout
    );

endinterface

// File: rtl/core_result_collector_capture.sv
// strobe_fall_capture: samples one core's result while its strobe is high and
// commits the last sample to core_result once the strobe falls.
module strobe_fall_capture #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              strobe,
    input  logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] core_result,
    output logic [DATA_W-1:0] result_nxt
);

    logic              strb_p0;
    logic              strb_p1;
    logic [DATA_W-1:0] sample_p0;
    logic              fall_p1;

    assign fall_p1    = strb_p1 & ~strb_p0;
    // Exposes the value core_result takes at the next edge so the summer can
    // include a capture that lands in the first SUM cycle.
    assign result_nxt = (en && fall_p1) ? sample_p0 : core_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            strb_p0     <= 1'b0;
            strb_p1     <= 1'b0;
            sample_p0   <= '0;
            core_result <= '0;
        end else begin
            // stage p0: strobe history and qualified sample
            strb_p0 <= strobe;
            if (strobe) begin
                sample_p0 <= result;
            end
            // stage p1: falling edge seen, commit the sample
            strb_p1     <= strb_p0;
            core_result <= result_nxt;
        end
    end

endmodule

// File: rtl/core_result_collector.sv
// core_result_collector: captures strobed per-core results, times the run until
// all cores complete, then sums the results one core per cycle.
// Optional watchdog enabled by defining COLLECTOR_TIMEOUT_EN.
module core_result_collector
    import collector_pkg::*;
#(
    parameter int NUM_CORES      = 2,
    parameter int DATA_W         = 8,
    parameter int SUM_W          = 10,
    parameter int CYC_W          = 32,
    parameter int RES_STROBE_BIT = RES_STROBE_BIT_DEF,
    parameter int COMPLETE_BIT   = COMPLETE_BIT_DEF
`ifdef COLLECTOR_TIMEOUT_EN
    ,
    parameter logic [CYC_W-1:0] TIMEOUT_CYCLES = 32'd1_000_000
`endif
) (
    input logic                   clk,
    input logic                   reset,
    core_result_collector_if.slave bus
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

    if (SUM_W < min_sum_w(DATA_W, NUM_CORES)) begin : g_sum_w_check
        $error("SUM_W too narrow for NUM_CORES results of DATA_W bits");
    end

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     idx;
    logic [SUM_W-1:0]     acc;
    logic [SUM_W-1:0]     addend;
    logic [SUM_W-1:0]     total_r;
    logic [CYC_W-1:0]     cycle_count_r;
    logic                 done_r;
    logic [NUM_CORES-1:0] comp_bits;
    logic                 all_complete;
    logic                 tmo_hit;
    logic                 go_sum;
    logic                 cap_en;
    logic [DATA_W-1:0]    cr_nxt [NUM_CORES];

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
        assign comp_bits[k] = bus.complete_bus[COMPLETE_W*k + COMPLETE_BIT];

        strobe_fall_capture #(.DATA_W(DATA_W)) u_cap (
            .clk         (clk),
            .reset       (reset),
            .en          (cap_en),
            .strobe      (bus.out_strobe[STROBE_W*k + RES_STROBE_BIT]),
            .result      (bus.result_bus[DATA_W*k +: DATA_W]),
            .core_result (bus.core_result[DATA_W*k +: DATA_W]),
            .result_nxt  (cr_nxt[k])
        );
    end

    assign all_complete = &comp_bits;
    assign go_sum       = all_complete | tmo_hit;
    // Captures stay live through the first SUM cycle, then freeze.
    assign cap_en       = (state == RUN) || ((state == SUM) && (idx == '0));
    assign addend       = SUM_W'(cr_nxt[idx]);

`ifdef COLLECTOR_TIMEOUT_EN
    logic tmo_flag;
    logic timeout_r;

    assign tmo_hit     = (cycle_count_r == TIMEOUT_CYCLES - 1'b1);
    assign bus.timeout = timeout_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_flag  <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            if (state == RUN && !all_complete && tmo_hit) begin
                tmo_flag <= 1'b1;
            end
            if (state == SUM && idx == LAST_IDX) begin
                timeout_r <= tmo_flag;
            end
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (go_sum) state_nxt = SUM;
            SUM:     if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx           <= '0;
            acc           <= '0;
            total_r       <= '0;
            cycle_count_r <= '0;
            done_r        <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (go_sum) begin
                        acc <= '0;
                        idx <= '0;
                    end else if (cycle_count_r != '1) begin
                        cycle_count_r <= cycle_count_r + 1'b1;
                    end
                end
                SUM: begin
                    acc <= acc + addend;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        total_r <= acc + addend;
                        done_r  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.total       = total_r;
    assign bus.cycle_count = cycle_count_r;
    assign bus.done        = done_r;

endmodule
